int_ctrl: RTL

Priority interrupt controller between the SoC's peripheral interrupt sources and the CPU's `interrupt`/`intVect`/`intAck` handshake. Latches rising-edge events from up to 8 sources, applies per-source and global enables, and presents one request at a time with its fixed vector. It holds off further requests until software writes end-of-interrupt. Software reaches it as a 4-byte register window on the data-memory/IO bus inside `d_ram_and_io`.

---
 rtl/int_ctrl_pkg.sv | 26 ++
 rtl/int_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the priority interrupt controller: register map,
// FSM encoding, CTRL bit positions and the vector address helper.
package int_ctrl_pkg;

  localparam logic [1:0] IC_IE   = 2'd0;
  localparam logic [1:0] IC_IF   = 2'd1;
  localparam logic [1:0] IC_CTRL = 2'd2;
  localparam logic [1:0] IC_EOI  = 2'd3;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

  localparam int CTRL_GIE_BIT   = 0;
  localparam int CTRL_INSRV_BIT = 1;

  // Vector address wraps modulo 2^16 by construction of the 16-bit result.
  function automatic logic [15:0] ic_vect(input logic [15:0] base,
                                          input logic [2:0]  idx,
                                          input logic [15:0] stride);
    return base + (16'(idx) * stride);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational lowest-set-bit encoder: bit 0 has the highest priority.
module int_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic [2:0]       idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Priority interrupt controller: edge-latched sources, IE/GIE masking, one
// request at a time to the CPU, held off until software writes EOI.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          N_SRC       = 8,
  parameter logic [15:0] VECT_BASE   = 16'h0008,
  parameter int          VECT_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             sel,
  input  logic [1:0]       address,
  input  logic [7:0]       din,
  input  logic             w_en,
  input  logic             r_en,
  output logic [7:0]       dout,
  output logic             interrupt,
  output logic [15:0]      intVect,
  input  logic             intAck
);

  localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

  ic_state_e        state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] ie_q, ie_d;
  logic [N_SRC-1:0] if_q, if_d;
  logic             gie_q, gie_d;
  logic [2:0]       active_idx_q, active_idx_d;
  logic [15:0]      vect_q, vect_d;
  logic [7:0]       dout_q, dout_d;

  logic [N_SRC-1:0] rise;
  logic             wr_hit, rd_hit, ack_hit;
  logic [2:0]       enc_idx;
  logic             enc_valid;
  logic [7:0]       rd_data;

  int_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req   (if_q & ie_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    rise    = src & ~src_q;
    wr_hit  = sel & w_en;
    rd_hit  = sel & r_en;
    ack_hit = (state_q == IC_REQ) & intAck;

    ie_d  = ie_q;
    gie_d = gie_q;
    if (wr_hit && address == IC_IE)   ie_d  = din[N_SRC-1:0];
    if (wr_hit && address == IC_CTRL) gie_d = din[CTRL_GIE_BIT];

    // Clears first, then OR in new events so a same-cycle set wins.
    if_d = if_q;
    if (wr_hit && address == IC_IF) if_d = if_d & ~din[N_SRC-1:0];
    if (ack_hit)                    if_d = if_d & ~(ONE_HOT0 << active_idx_q);
    if_d = if_d | rise;

    rd_data = 8'h00;
    case (address)
      IC_IE:   rd_data = 8'(ie_q);
      IC_IF:   rd_data = 8'(if_q);
      IC_CTRL: begin
        rd_data[CTRL_GIE_BIT]   = gie_q;
        rd_data[CTRL_INSRV_BIT] = (state_q == IC_SERVICE);
      end
      default: rd_data = {5'b0, active_idx_q};
    endcase
    dout_d = rd_hit ? rd_data : dout_q;
  end

  always_comb begin
    state_d      = state_q;
    active_idx_d = active_idx_q;
    vect_d       = vect_q;
    case (state_q)
      IC_IDLE: begin
        if (gie_q && enc_valid) begin
          active_idx_d = enc_idx;
          vect_d       = ic_vect(VECT_BASE, enc_idx, 16'(VECT_STRIDE));
          state_d      = IC_REQ;
        end
      end
      IC_REQ: begin
        if (intAck) state_d = IC_SERVICE;
      end
      IC_SERVICE: begin
        if (wr_hit && address == IC_EOI) state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IC_IDLE;
      src_q        <= src;
      ie_q         <= '0;
      if_q         <= '0;
      gie_q        <= 1'b0;
      active_idx_q <= '0;
      vect_q       <= VECT_BASE;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src;
      ie_q         <= ie_d;
      if_q         <= if_d;
      gie_q        <= gie_d;
      active_idx_q <= active_idx_d;
      vect_q       <= vect_d;
      dout_q       <= dout_d;
    end
  end

  assign interrupt = (state_q == IC_REQ);
  assign intVect   = vect_q;
  assign dout      = dout_q;

endmodule
